// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states,
// fault causes and the latched request record.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Stores only have sb/sh/sw; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    if (st) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Unified memory port between the load/store sequencer and instruction/data memory.
interface lsu_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl_extend.sv
// Load-data lane select and sign/zero extension; purely combinational so it can
// also sit on a cache refill path.
module lsu_extend
  import lsu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_B:    rdata = {{(XLEN-8){b[7]}}, b};
      F3_H:    rdata = {{(XLEN-16){h[15]}}, h};
      F3_BU:   rdata = {{(XLEN-8){1'b0}}, b};
      F3_HU:   rdata = {{(XLEN-16){1'b0}}, h};
      default: rdata = data;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: one access per start pulse over a req/ready port.
// Define LSU_TIMEOUT_EN to add a wait-state watchdog that faults after TIMEOUT cycles.
module lsu_ctrl
  import lsu_defs::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_cause,
  output logic [XLEN-1:0] rdata_out,
  lsu_ctrl_if.master      mem
);
  if (XLEN != 32) begin : g_bad_xlen
    $error("lsu_ctrl supports XLEN=32 only");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lsu_ctrl TIMEOUT must be at least 1");
  end

  lsu_state_t      state, state_nxt;
  lsu_req_t        req_q;
  logic            accept, cause_ld, timeout_hit, in_req;
  logic [1:0]      cause_nxt;
  logic [3:0]      be;
  logic [XLEN-1:0] lane_data, ext_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 wcnt <= '0;
    else if (accept)                           wcnt <= '0;
    else if (state == S_REQ && !mem.mem_ready) wcnt <= wcnt + 1'b1;
  end
  // Fires on the wait cycle that would bring the count up to TIMEOUT.
  assign timeout_hit = (wcnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cause_ld  = 1'b0;
    cause_nxt = err_cause;
    case (state)
      S_IDLE: if (start) begin
        if (!f3_legal(we, funct3)) begin
          state_nxt = S_ERR;
          cause_ld  = 1'b1;
          cause_nxt = ERR_ILLEGAL;
        end else if (misaligned(funct3[1:0], addr[1:0])) begin
          state_nxt = S_ERR;
          cause_ld  = 1'b1;
          cause_nxt = ERR_MISALIGN;
        end else begin
          state_nxt = S_REQ;
          accept    = 1'b1;
        end
      end
      S_REQ: begin
        if (mem.mem_ready) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
          cause_ld  = 1'b1;
          cause_nxt = ERR_TIMEOUT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_q     <= '0;
      err_cause <= 2'b00;
      rdata_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept)   req_q     <= '{we: we, funct3: funct3, addr: addr, wdata: wdata};
      if (cause_ld) err_cause <= cause_nxt;
      if (state == S_REQ && mem.mem_ready && !req_q.we) rdata_out <= ext_data;
    end
  end

  // Sub-word stores replicate the datum into every lane; be picks the live one.
  always_comb begin
    be        = 4'b1111;
    lane_data = req_q.wdata;
    if (req_q.we) begin
      case (req_q.funct3[1:0])
        2'b00: begin
          be        = 4'b0001 << req_q.addr[1:0];
          lane_data = {(XLEN/8){req_q.wdata[7:0]}};
        end
        2'b01: begin
          be        = 4'b0011 << req_q.addr[1:0];
          lane_data = {(XLEN/16){req_q.wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  lsu_extend #(.XLEN(XLEN)) u_ext (
    .funct3 (req_q.funct3),
    .lane   (req_q.addr[1:0]),
    .data   (mem.mem_rdata),
    .rdata  (ext_data)
  );

  assign in_req        = (state == S_REQ);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERR);
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & req_q.we;
  assign mem.mem_addr  = in_req ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
  assign mem.mem_be    = in_req ? be : 4'b0000;
  assign mem.mem_wdata = (in_req && req_q.we) ? lane_data : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a per-cycle expectation model built from the
// access rules, plus literal checks on the documented example accesses.
module tb_lsu_ctrl;
`ifdef LSU_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_TO = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        busy, done, err;
  logic [1:0]  err_cause;
  logic [31:0] rdata_out;

  lsu_ctrl_if mif ();

  lsu_ctrl #(.XLEN(32), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .err_cause(err_cause), .rdata_out(rdata_out), .mem(mif)
  );

  always #5 clk = ~clk;

  // expected outputs for the current cycle, maintained by the stimulus process
  logic        exp_busy = 0, exp_done = 0, exp_err = 0, exp_req = 0, exp_we = 0;
  logic [1:0]  exp_cause = 0;
  logic [31:0] exp_rdata = 0, exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;

  // literal-check mailbox, consumed by the compare process
  bit          lit_req = 0;
  string       lit_name = "";
  logic [31:0] lit_act = 0, lit_exp = 0;

  int n_tests = 0, n_fail = 0;
  int neg_cnt = 0, done_neg = 0, err_neg = 0, req_run = 0, last_req_run = 0;
  logic [31:0] cap_addr = 0, cap_wdata = 0;
  logic [3:0]  cap_be = 0;
  logic        cap_we = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, neg_cnt);
    end
  endtask

  always @(negedge clk) begin
    neg_cnt++;
    cmp("busy", 32'(busy), 32'(exp_busy));
    cmp("done", 32'(done), 32'(exp_done));
    cmp("err", 32'(err), 32'(exp_err));
    cmp("err_cause", 32'(err_cause), 32'(exp_cause));
    cmp("rdata_out", rdata_out, exp_rdata);
    cmp("mem_req", 32'(mif.mem_req), 32'(exp_req));
    if (exp_req) begin
      cmp("mem_we", 32'(mif.mem_we), 32'(exp_we));
      cmp("mem_addr", mif.mem_addr, exp_addr);
      cmp("mem_be", 32'(mif.mem_be), 32'(exp_be));
      if (exp_we) cmp("mem_wdata", mif.mem_wdata, exp_wdata);
    end
    if (reset) req_run = 0;
    if (mif.mem_req) begin
      req_run++;
      cap_addr = mif.mem_addr; cap_be = mif.mem_be;
      cap_wdata = mif.mem_wdata; cap_we = mif.mem_we;
    end
    if (done || err) begin last_req_run = req_run; req_run = 0; end
    if (done) done_neg = neg_cnt;
    if (err)  err_neg = neg_cnt;
    if (lit_req) cmp(lit_name, lit_act, lit_exp);
  end

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
    int unsigned bv, hv;
    bv = (d >> (8 * a[1:0])) & 32'hFF;
    hv = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (bv >= 128) ? bv - 256 : bv;
      3'b001:  return (hv >= 32768) ? hv - 65536 : hv;
      3'b100:  return bv;
      3'b101:  return hv;
      default: return d;
    endcase
  endfunction

  task automatic set_idle();
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_req = 0;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    lit_name = nm; lit_act = act; lit_exp = expv; lit_req = 1;
    @(negedge clk); #1 lit_req = 0;
    @(posedge clk); #1;
  endtask

  // One access; entered and left at posedge+1 with the DUT idle.
  // s is the negedge count at issue, so the cycle after edge t has count s+2.
  task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        output int s);
    bit legal, mis;
    int size, i;
    s = neg_cnt;
    start = 1; we = w; funct3 = f3; addr = a; wdata = wd; mif.mem_ready = 0;
    @(posedge clk); #1;
    start = 1'($urandom_range(0, 1)); we = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    mis = (int'(a[1:0]) % size) != 0;
    exp_busy = 1;
    if (!legal || mis) begin
      exp_err = 1; exp_cause = !legal ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      start = 0; set_idle();
      return;
    end
    exp_req = 1; exp_we = w; exp_addr = a & ~32'h3;
    exp_be = w ? 4'(((1 << size) - 1) << a[1:0]) : 4'hF;
    exp_wdata = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    i = 0;
    forever begin
      mif.mem_ready = (i == waits);
      mif.mem_rdata = (i == waits) ? rd : $urandom;
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      if (i == waits) begin
        exp_req = 0; exp_done = 1;
        if (!w) exp_rdata = ext_model(f3, a, rd);
        break;
      end
      if (TO_EN && i + 1 == TB_TO) begin
        exp_req = 0; exp_err = 1; exp_cause = 2'b11;
        break;
      end
      i++;
    end
    mif.mem_ready = 1'($urandom_range(0, 1)); mif.mem_rdata = $urandom;
    @(posedge clk); #1;
    start = 0; mif.mem_ready = 0; set_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic r_req, r_busy, r_done, r_err;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic w;
    logic [2:0] f3;
    mif.mem_ready = 0; mif.mem_rdata = 0;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;

    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, s);
    lit("lw_done_latency", 32'(done_neg - s - 1), 32'd5);
    lit("lw_req_cycles", 32'(last_req_run), 32'd4);
    lit("lw_be", 32'(cap_be), 32'hF);
    lit("lw_rdata", rdata_out, 32'hDEADBEEF);

    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233, s);
    lit("lb_rdata", rdata_out, 32'hFFFFFF80);
    lit("lb_latency", 32'(done_neg - s - 1), 32'd2);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233, s);
    lit("lbu_rdata", rdata_out, 32'h00000080);

    do_txn(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1, 32'h0, s);
    lit("sh_we", 32'(cap_we), 32'd1);
    lit("sh_be", 32'(cap_be), 32'hC);
    lit("sh_wdata", cap_wdata, 32'hABCDABCD);
    lit("sh_addr", cap_addr, 32'h100);

    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, s);
    lit("mis_latency", 32'(err_neg - s - 1), 32'd1);
    lit("mis_cause", 32'(err_cause), 32'd1);
    lit("mis_no_req", 32'(last_req_run), 32'd0);
    do_txn(1'b1, 3'b011, 32'h200, 32'h0, 0, 32'h0, s);
    lit("ill_cause", 32'(err_cause), 32'd2);

    // reset while waiting on memory
    start = 1; we = 0; funct3 = 3'b010; addr = 32'h300; wdata = 0; mif.mem_ready = 0;
    @(posedge clk); #1;
    start = 0;
    exp_busy = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h300; exp_be = 4'hF;
    @(posedge clk); #1;
    reset = 1; set_idle(); exp_cause = 0; exp_rdata = 0;
    #1 r_req = mif.mem_req; r_busy = busy; r_done = done; r_err = err;
    @(negedge clk); #1;
    @(posedge clk); #1;
    lit("rst_mem_req", 32'(r_req), 32'd0);
    lit("rst_busy", 32'(r_busy), 32'd0);
    lit("rst_done", 32'(r_done), 32'd0);
    lit("rst_err", 32'(r_err), 32'd0);
    reset = 0;
    @(posedge clk); #1;
    do_txn(1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h12345678, s);
    lit("post_rst_rdata", rdata_out, 32'h12345678);

    if (TO_EN) begin
      do_txn(1'b0, 3'b010, 32'h80, 32'h0, 20, 32'h0, s);
      lit("to_cause", 32'(err_cause), 32'd3);
      lit("to_req_cycles", 32'(last_req_run), 32'(TB_TO));
      do_txn(1'b0, 3'b010, 32'h84, 32'h0, TB_TO - 1, 32'hCAFEF00D, s);
      lit("to_ready_wins", rdata_out, 32'hCAFEF00D);
    end

    repeat (300) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else f3 = w ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      do_txn(w, f3, $urandom, $urandom, $urandom_range(0, TO_EN ? 6 : 4), $urandom, s);
      repeat ($urandom_range(0, 2)) begin
        mif.mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      mif.mem_ready = 0;
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the multicycle control FSM and the unified instruction/data memory port.
- On a one-cycle start from the FSM, runs one RV32I load or store via a req/ready memory handshake with variable wait states.
- Generates byte enables and store-lane replication, and sign/zero-extends load data.
- Reports completion or a fault back to the FSM, which holds in its memory-access state while busy is high.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- TIMEOUT, 255, max cycles in REQ without mem_ready before a timeout fault (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  FSM request pulse; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code.
- addr  in  XLEN  byte address (ALU result).
- wdata  in  XLEN  store data (rs2).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on fault.
- err_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; held until the next err.
- rdata_out  out  XLEN  extended load result; held until the next load completes.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ready  in  1  memory accepts/returns in the current cycle.
- mem_rdata  in  XLEN  read data, valid with mem_ready.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is async: mem_req drops immediately, even mid-transaction; the in-flight access is abandoned without done or err.
- States: IDLE, REQ, DONE, ERR.
- IDLE + start:
  - Illegal funct3 (load 011/110/111; store anything above 010) -> ERR, cause 10.
  - Else misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> ERR, cause 01.
  - Else -> REQ. addr, we, funct3 and wdata are latched at this edge; later input changes are ignored.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata stay stable until mem_ready is sampled high.
  - mem_ready=1 -> DONE; on loads, mem_rdata is extended into rdata_out at that edge.
  - Zero-wait (ready in the first REQ cycle) is legal.
- DONE: done=1 for exactly one cycle -> IDLE.
- ERR: err=1 for exactly one cycle -> IDLE. No memory request is ever issued for an illegal or misaligned access.
- Latency: start at edge t -> mem_req in cycle t+1. Zero-wait gives done in cycle t+2; N wait states give done in cycle t+2+N. Error path: err in cycle t+1.
- start while not IDLE is ignored (no queueing).
- Byte enables and store data:
  - sb: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: be = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - sw: be = 1111.
  - Loads drive be=1111 and mem_we=0.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Wait counter clears on REQ entry and increments each REQ cycle with mem_ready=0.
  - When the count reaches TIMEOUT -> ERR with cause 11; mem_req drops the next cycle.
  - A mem_ready in the same cycle the count reaches TIMEOUT wins (-> DONE).
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Package lsu_defs:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t enum.
  - err_cause constants ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT.
- Sub-module lsu_extend: combinational lane select and sign/zero extension (funct3, addr[1:0], mem_rdata -> rdata). Reusable for future cache refill paths.

Test Plan:
- lw addr=0x100, mem_ready after 3 waits, mem_rdata=0xDEADBEEF -> mem_be=1111; mem_req high 4 cycles; done in cycle t+5; rdata_out=0xDEADBEEF.
- lb addr=0x103, mem_rdata=0x80112233, zero-wait -> rdata_out=0xFFFFFF80. lbu at the same address -> rdata_out=0x00000080.
- sh addr=0x102, wdata=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x100.
- lw addr=0x101 -> err pulse in cycle t+1, err_cause=01, mem_req never asserted. Store with funct3=011 -> err_cause=10.
- Reset asserted mid-REQ with mem_ready low -> mem_req=0 immediately; done and err stay 0; busy=0; next start proceeds normally.
- LSU_TIMEOUT_EN, TIMEOUT=4, mem_ready held low -> err with err_cause=11 after 4 REQ cycles. Ready arriving at count 4 -> done instead.
